// File: rtl/twiddle_mult_sched.sv
// twiddle_mult_sched
//   Round-robin front end that shares one constant x0.7071 shift-add multiplier
//   (the W8^1 real scale) among NUM_REQ butterfly requesters. Operands enter a
//   two-stage pipeline: S1 holds {valid, id, operand}, and S2 holds
//   {valid, id, product}. The product is formed combinationally from S1.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ-1:0]     per-requester operand valid
//   req_data   in   [NUM_REQ*32-1:0]  operand of requester i at [32*i +: 32]
//   req_ready  out  [NUM_REQ-1:0]     one-hot grant (combinational)
//   rsp_valid  out  product valid (driven from S2)
//   rsp_id     out  [ID_W-1:0]        requester ID of the product
//   rsp_data   out  [31:0]            signed product
//   rsp_ready  in   consumer accepts the product
//   stall_cnt  out  [15:0]            present only with TWID_SCHED_STATS_EN:
//                                     saturating count of rsp_valid && !rsp_ready cycles
//
// Build option: define TWID_SCHED_STATS_EN to add the stall_cnt port.

module twiddle_mult_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
`ifdef TWID_SCHED_STATS_EN
    output logic [15:0]             stall_cnt,
`endif
    input  logic                    rsp_ready
);

    // Each term is truncated toward -inf on its own, and the sum wraps at 32 bits.
    function automatic logic [31:0] twiddle_mul(input logic signed [31:0] x);
        return (x >>> 1) + (x >>> 3) + (x >>> 4) + (x >>> 6) + (x >>> 8) + (x >>> 10);
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q,    s1_id_d;
    logic [31:0]       s1_data_q,  s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]   s2_id_q,    s2_id_d;
    logic [31:0]       s2_data_q,  s2_data_d;
    logic [ID_W-1:0]   ptr_q,      ptr_d;

    logic              s2_load;
    logic              s1_load;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_id;
    logic              granted;

    assign s2_load = !s2_valid_q || rsp_ready;
    assign s1_load = !s1_valid_q || s2_load;

    // Search starts at the pointer and ascends with wraparound. The first valid
    // requester found wins the grant.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        granted  = 1'b0;
        idx      = 0;
        if (!rst && s1_load) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!granted && req_valid[idx]) begin
                    granted    = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                end
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_data_d  = s2_data_q;
        ptr_d      = ptr_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s2_id_d    = s1_id_q;
            s2_data_d  = twiddle_mul(s1_data_q);
        end
        if (s1_load) begin
            s1_valid_d = granted;
            s1_id_d    = grant_id;
            s1_data_d  = req_data[32*int'(grant_id) +: 32];
        end
        if (granted) begin
            ptr_d = ID_W'((int'(grant_id) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
            ptr_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_data_q  <= s2_data_d;
            ptr_q      <= ptr_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;

`ifdef TWID_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s2_valid_q && !rsp_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_twiddle_mult_sched.sv
// tb_twiddle_mult_sched
//   Directed bench for twiddle_mult_sched with NUM_REQ=4. Inputs are driven
//   1 time unit after the rising edge, and outputs are sampled on the falling edge.

module tb_twiddle_mult_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_ready;
`ifdef TWID_SCHED_STATS_EN
    logic [15:0]           stall_cnt;
`endif

    int n_chk;
    int n_fail;

    twiddle_mult_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
`ifdef TWID_SCHED_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed single-request vectors: requester, operand, hand-computed product.
    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 32'h0001_0000, 32'h0000_B540};
        vecs[1] = '{1, 32'hFFFF_0000, 32'hFFFF_4AC0};
        vecs[2] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[3] = '{3, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{0, 32'h0000_0400, 32'h0000_02D5};
        vecs[5] = '{1, 32'hFFFF_FF9C, 32'hFFFF_FFB6};   // -100 -> -74
        vecs[6] = '{2, 32'h8000_0000, 32'hA560_0000};

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state
        step();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_rsp_data",  rsp_data,       32'h0);
`ifdef TWID_SCHED_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
        step();
        rst       = 1'b0;
        req_valid = '0;

        // Single requests with arithmetic vectors
        foreach (vecs[i]) begin
            req_valid = '0;
            req_valid[vecs[i].id] = 1'b1;
            req_data[32*vecs[i].id +: 32] = vecs[i].x;
            @(negedge clk);
            chk($sformatf("single%0d_grant", i), 32'(req_ready), 32'(1) << vecs[i].id);
            step();
            req_valid = '0;
            @(negedge clk);
            chk($sformatf("single%0d_lat1", i), 32'(rsp_valid), 32'h0);
            step();
            @(negedge clk);
            chk($sformatf("single%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("single%0d_id", i),    32'(rsp_id),    32'(vecs[i].id));
            chk($sformatf("single%0d_data", i),  rsp_data,       vecs[i].p);
            step();
        end

        // Round-robin with all requesters valid. Requester k sends (k+1)*1024,
        // which gives the exact product (k+1)*725.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = 32'((k + 1) * 1024);
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_grant", c), 32'(req_ready), 32'(1) << (c % 4));
            if (c < 2) begin
                chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'h0);
            end else begin
                chk($sformatf("rr%0d_valid", c), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr%0d_id", c),    32'(rsp_id),    32'((c - 2) % 4));
                chk($sformatf("rr%0d_data", c),  rsp_data,       32'(((c - 2) % 4 + 1) * 725));
            end
            step();
        end

        // Backpressure from an empty pipeline with all requesters valid
        rst = 1'b1;
        step();
        rst       = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp0_grant", 32'(req_ready), 32'h1);
        step();
        @(negedge clk);
        chk("bp1_grant", 32'(req_ready), 32'h2);
        step();
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_grant", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_id", c),    32'(rsp_id),    32'h0);
            chk($sformatf("bp%0d_data", c),  rsp_data,       32'd725);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp7_grant", 32'(req_ready), 32'h4);
        chk("bp7_id",    32'(rsp_id),    32'h0);
        chk("bp7_data",  rsp_data,       32'd725);
`ifdef TWID_SCHED_STATS_EN
        chk("bp7_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        step();
        @(negedge clk);
        chk("bp8_grant", 32'(req_ready), 32'h8);
        chk("bp8_id",    32'(rsp_id),    32'h1);
        chk("bp8_data",  rsp_data,       32'd1450);
        step();
        @(negedge clk);
        chk("bp9_valid", 32'(rsp_valid), 32'h1);
        chk("bp9_id",    32'(rsp_id),    32'h2);
        chk("bp9_data",  rsp_data,       32'd2175);
        step();

        // Mid-operation reset with S1 and S2 full and the pointer at 1.
        // Requesters 0 and 2 stay valid. A stale pointer would pick 2, but
        // after reset the grant must go to 0.
        rst       = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        chk("mrst_grant_in_rst", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mrst_grant",     32'(req_ready), 32'h1);
`ifdef TWID_SCHED_STATS_EN
        chk("mrst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
        step();
        req_valid = '0;
        @(negedge clk);
        chk("mrst_lat1", 32'(rsp_valid), 32'h0);
        step();
        @(negedge clk);
        chk("mrst_valid", 32'(rsp_valid), 32'h1);
        chk("mrst_id",    32'(rsp_id),    32'h0);
        chk("mrst_data",  rsp_data,       32'd725);
        step();
        @(negedge clk);
        chk("mrst_drained", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_mult_sched.md
Name: twiddle_mult_sched

Overview:
- Round-robin scheduler that shares one constant twiddle multiplier (x0.7071, the W8^1 real-scale shift-add datapath) among NUM_REQ FFT butterfly requesters.
- Accepts one operand per cycle, pushes it through a 2-stage registered pipeline around the shared combinational shift-add multiplier, and returns the product tagged with the requester ID.
- Sits between the radix-2 butterfly stages and the shared multiplier so that only one multiplier instance is needed per FFT stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*32  signed operands; requester i occupies bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot grant; operand i is accepted on a clock edge where req_valid[i] && req_ready[i].
- rsp_valid  out  1  product valid.
- rsp_id  out  ID_W  requester ID of the product.
- rsp_data  out  32  signed product.
- rsp_ready  in  1  consumer accepts the product.

Behaviour:
- Reset: rsp_valid=0, rsp_id=0, rsp_data=0, both pipeline valids=0, RR pointer=0. req_ready is 0 during reset because grants are suppressed while rst=1.
- Pipeline: S1 holds {valid, id, operand}; S2 holds {valid, id, product}. The product is computed combinationally from the S1 operand and is not registered until it enters S2.
- Advance rules:
  - S2 loads when !S2.valid || rsp_ready.
  - S1 loads when !S1.valid || (S2 loads).
  - Grant is allowed only when S1 loads.
- Arbitration: combinational round-robin.
  - Search starts at the RR pointer and ascends, wrapping modulo NUM_REQ.
  - The first requester with req_valid set gets req_ready; at most one bit of req_ready is high.
  - On an accepted grant to requester i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Latency: an operand accepted at edge T appears with rsp_valid=1 after edge T+1 when there is no backpressure.
- Throughput: 1 operand per cycle, sustained.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_id hold stable. S1 stays full and req_ready is all-zero. No data is lost or duplicated.
- Simultaneous events: S2 drain and S1 refill occur in the same cycle. A new grant in the same cycle as a response handshake is legal.
- Arithmetic:
  - product = (x>>>1)+(x>>>3)+(x>>>4)+(x>>>6)+(x>>>8)+(x>>>10).
  - Each shift is an arithmetic right shift that truncates toward -inf independently of the others.
  - Sums are 32-bit and wrap modulo 2^32; there is no saturation and no rounding.
- Ordering: responses return in grant order. rsp_id is the ID latched at grant.
- Reset mid-operation: in-flight operands are discarded. rsp_valid drops on the edge where rst=1 is sampled, and the pointer returns to 0.
- Requester behaviour: a requester must hold req_data stable while req_valid=1 and not yet granted. A request may be withdrawn before grant.

Optional Feature:
- Macro: TWID_SCHED_STATS_EN.
- When defined:
  - Adds output port stall_cnt (out, 16 bits).
  - stall_cnt increments on every cycle with rsp_valid && !rsp_ready and saturates at 0xFFFF.
  - stall_cnt is cleared to 0 by rst.
- When not defined: the port and its counter do not exist, and the remaining behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends x=0x00010000; rsp_ready=1.
  - Response: rsp_valid=1 two edges after acceptance, rsp_id=0, rsp_data=0x0000B540 (46400).
- Sign and truncation:
  - Stimulus: x=0xFFFF0000, then x=0xFFFFFFFF.
  - Response: rsp_data=0xFFFF4AC0, then 0xFFFFFFFA (six -1 terms); x=0x00000000 gives 0.
- Round-robin:
  - Stimulus: all 4 requesters hold valid continuously.
  - Response: grants occur in order 0,1,2,3,0,... on consecutive cycles; rsp_id follows the same order, one per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles while all requesters stay valid.
  - Response: at most 2 operands are accepted, rsp_data/rsp_id stay stable, req_ready=0. After release, products drain in order with no loss.
  - With TWID_SCHED_STATS_EN defined: stall_cnt=5.
- Mid-operation reset:
  - Stimulus: assert rst for 1 cycle with S1 and S2 both full.
  - Response: next cycle rsp_valid=0, pointer=0, and the next grant goes to the lowest valid requester.
